// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared op-code and state encodings for the multiply/divide unit
//            and the CPU controller that drives it.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Op encoding: bit 1 selects divide, bit 0 selects unsigned.
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sign_fix
// Brief    : Combinational conditional two's-complement negate of an N-bit
//            value. Used for operand magnitudes and result sign correction.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sign_fix #(
    parameter int N = 32
) (
    input  logic         neg,
    input  logic [N-1:0] val,
    output logic [N-1:0] res
);

    // Negate when requested; the most-negative value maps onto itself, which
    // read as unsigned is exactly its magnitude.
    assign res = neg ? ({N{1'b0}} - val) : val;

endmodule : muldiv_sign_fix
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Multi-cycle MULT/MULTU/DIV/DIVU engine sharing one shift/add-sub
//            datapath. Fixed latency of WIDTH+2 cycles, results in HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_m;      // multiplicand (multiply) or divisor (divide)
    logic [2*WIDTH-1:0]   r_acc;    // {upper/remainder, multiplier/quotient}
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg_q;  // negate product / quotient in FIX
    logic                 r_neg_r;  // negate remainder in FIX

    logic                 w_signed;
    logic                 w_is_div;
    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_shift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_sub;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic                 w_b_zero;

    assign w_signed = (r_op == OP_MULT) || (r_op == OP_DIV);
    assign w_is_div = (r_op == OP_DIV)  || (r_op == OP_DIVU);
    assign w_neg_a  = w_signed & r_a[WIDTH-1];
    assign w_neg_b  = w_signed & r_b[WIDTH-1];
    assign w_b_zero = (r_b == '0);
    assign busy     = (r_state != IDLE);

    muldiv_sign_fix #(.N(WIDTH)) u_mag_a (.neg(w_neg_a), .val(r_a), .res(w_mag_a));
    muldiv_sign_fix #(.N(WIDTH)) u_mag_b (.neg(w_neg_b), .val(r_b), .res(w_mag_b));

    // Radix-2 shift-add: add multiplicand to the upper half when the LSB of
    // the multiplier is set, then shift the whole accumulator right with carry.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the partial remainder
    // and subtract when it fits. The difference is below the divisor, so the
    // low WIDTH bits of the modular subtraction are exact.
    assign w_shift    = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge       = (w_shift >= {1'b0, r_m});
    assign w_sub      = w_shift[WIDTH-1:0] - r_m;
    assign w_div_next = {(w_ge ? w_sub : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

    muldiv_sign_fix #(.N(2*WIDTH)) u_fix_prod (.neg(r_neg_q), .val(r_acc),                    .res(w_prod));
    muldiv_sign_fix #(.N(WIDTH))   u_fix_quo  (.neg(r_neg_q), .val(r_acc[WIDTH-1:0]),         .res(w_quo));
    muldiv_sign_fix #(.N(WIDTH))   u_fix_rem  (.neg(r_neg_r), .val(r_acc[2*WIDTH-1:WIDTH]),   .res(w_rem));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic: fixed sequence PREP, WIDTH x RUN, FIX.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = PREP;
            PREP:    w_next = RUN;
            RUN:     if (r_cnt == C_LAST) w_next = FIX;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: operand capture, magnitude load, iteration and result write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            dbz     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op <= op;
                        r_a  <= a;
                        r_b  <= b;
                    end
                end
                PREP: begin
                    r_cnt   <= '0;
                    r_neg_q <= w_neg_a ^ w_neg_b;
                    r_neg_r <= w_neg_a;
                    if (w_is_div) begin
                        r_m   <= w_mag_b;
                        r_acc <= {{WIDTH{1'b0}}, w_mag_a};
                    end else begin
                        r_m   <= w_mag_a;
                        r_acc <= {{WIDTH{1'b0}}, w_mag_b};
                    end
                end
                RUN: begin
                    r_acc <= w_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    if (!w_is_div) begin
                        {hi, lo} <= w_prod;
                        dbz      <= 1'b0;
                    end else if (w_b_zero) begin
                        lo  <= '1;
                        hi  <= r_a;
                        dbz <= 1'b1;
                    end else begin
                        lo  <= w_quo;
                        hi  <= w_rem;
                        dbz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Directed self-checking bench for muldiv_unit, WIDTH=32 and 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .dbz(dbz)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .dbz(dbz8)
    );

    // Drive one start pulse; returns at the negedge just after the accepting edge.
    task automatic launch32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count busy cycles until done, bounded; returns sitting in the done cycle.
    task automatic wait_done32(output int nb, output bit seen);
        nb = 0; seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) nb++;
                @(negedge clk);
            end
        end
    endtask

    task automatic launch8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_done8(output int nb, output bit seen);
        nb = 0; seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (done8) seen = 1'b1;
            else begin
                if (busy8) nb++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo: got %h_%h want 0_0", hi, lo); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", dbz); end
        checks++; if (busy8 !== 1'b0 || hi8 !== 8'h0 || lo8 !== 8'h0) begin errors++; $display("FAIL reset_w8: got busy=%b hi=%h lo=%h want 0", busy8, hi8, lo8); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_mult();
        int nb; bit seen;
        launch32(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done32(nb, seen);
        checks++; if (!seen) begin errors++; $display("FAIL mult_timeout: no done"); end
        checks++; if (nb !== 34) begin errors++; $display("FAIL mult_latency: got %0d want 34", nb); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_in_done: got %b want 0", busy); end
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_neg: got %h_%h want ffffffff_ffffffeb", hi, lo); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL mult_dbz: got %b want 0", dbz); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b want 0", done); end

        launch32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done32(nb, seen);
        checks++; if (!seen || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_max: got %h_%h want fffffffe_00000001", hi, lo); end

        launch32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done32(nb, seen);
        checks++; if (!seen || hi !== 32'h0 || lo !== 32'h1) begin errors++; $display("FAIL mult_m1_m1: got %h_%h want 00000000_00000001", hi, lo); end
    endtask

    task automatic test_div();
        int nb; bit seen;
        launch32(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done32(nb, seen);
        checks++; if (!seen || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg: got q=%h r=%h want q=fffffffd r=ffffffff", lo, hi); end

        launch32(2'b10, 32'd7, 32'hFFFF_FFFE);
        wait_done32(nb, seen);
        checks++; if (!seen || lo !== 32'hFFFF_FFFD || hi !== 32'h1) begin errors++; $display("FAIL div_negdivisor: got q=%h r=%h want q=fffffffd r=00000001", lo, hi); end

        launch32(2'b11, 32'd7, 32'd2);
        wait_done32(nb, seen);
        checks++; if (!seen || lo !== 32'd3 || hi !== 32'd1) begin errors++; $display("FAIL divu_7_2: got q=%h r=%h want q=3 r=1", lo, hi); end
        checks++; if (nb !== 34) begin errors++; $display("FAIL divu_latency: got %0d want 34", nb); end

        launch32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done32(nb, seen);
        checks++; if (!seen || lo !== 32'h8000_0000 || hi !== 32'h0 || dbz !== 1'b0) begin errors++; $display("FAIL div_overflow: got q=%h r=%h dbz=%b want q=80000000 r=0 dbz=0", lo, hi, dbz); end
    endtask

    task automatic test_dbz();
        int nb; bit seen;
        launch32(2'b11, 32'd5, 32'd0);
        wait_done32(nb, seen);
        checks++; if (!seen || lo !== 32'hFFFF_FFFF || hi !== 32'd5) begin errors++; $display("FAIL divu_by_zero: got q=%h r=%h want q=ffffffff r=5", lo, hi); end
        checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL dbz_set: got %b want 1", dbz); end
        checks++; if (nb !== 34) begin errors++; $display("FAIL dbz_latency: got %0d want 34", nb); end

        launch32(2'b01, 32'd2, 32'd3);
        wait_done32(nb, seen);
        checks++; if (!seen || hi !== 32'h0 || lo !== 32'd6 || dbz !== 1'b0) begin errors++; $display("FAIL dbz_clear_mult: got %h_%h dbz=%b want 0_6 dbz=0", hi, lo, dbz); end

        launch32(2'b10, 32'hFFFF_FFFB, 32'd0);
        wait_done32(nb, seen);
        checks++; if (!seen || lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFFB || dbz !== 1'b1) begin errors++; $display("FAIL div_by_zero_signed: got q=%h r=%h dbz=%b want q=ffffffff r=fffffffb dbz=1", lo, hi, dbz); end

        launch32(2'b11, 32'd9, 32'd4);
        wait_done32(nb, seen);
        checks++; if (!seen || lo !== 32'd2 || hi !== 32'd1 || dbz !== 1'b0) begin errors++; $display("FAIL dbz_clear_div: got q=%h r=%h dbz=%b want q=2 r=1 dbz=0", lo, hi, dbz); end
    endtask

    task automatic test_ignore_start();
        int nb; bit seen; int extra;
        launch32(2'b01, 32'h0001_0000, 32'h0001_0000);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd0; b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd1; b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done32(nb, seen);
        checks++; if (!seen || hi !== 32'h1 || lo !== 32'h0) begin errors++; $display("FAIL ignore_start_result: got %h_%h want 00000001_00000000", hi, lo); end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_start_single_done: got %0d extra busy/done cycles want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int nb; bit seen;
        launch32(2'b00, 32'hFFFF_FFFF, 32'd2);
        wait_done32(nb, seen);
        checks++; if (!seen || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_first: got %h_%h want ffffffff_fffffffe", hi, lo); end
        start = 1'b1; op = 2'b11; a = 32'hFFFF_FFFF; b = 32'h10;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
        wait_done32(nb, seen);
        checks++; if (!seen || lo !== 32'h0FFF_FFFF || hi !== 32'hF) begin errors++; $display("FAIL b2b_second: got q=%h r=%h want q=0fffffff r=f", lo, hi); end
        checks++; if (nb !== 34) begin errors++; $display("FAIL b2b_latency: got %0d want 34", nb); end
    endtask

    task automatic test_operand_change();
        int nb; bit seen;
        launch32(2'b11, 32'd100, 32'd7);
        op = 2'b00; a = 32'd3; b = 32'd3;
        repeat (3) @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        wait_done32(nb, seen);
        checks++; if (!seen || lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL operand_latch: got q=%h r=%h want q=e r=2", lo, hi); end
    endtask

    task automatic test_midop_reset();
        int cnt;
        launch32(2'b10, 32'hFFFF_FF00, 32'd3);
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_busy: got busy=%b done=%b want 0 0", busy, done); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midreset_hilo: got %h_%h want 0_0", hi, lo); end
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        checks++; if (cnt !== 0 || hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midreset_no_done: got done_count=%0d hi=%h lo=%h want 0", cnt, hi, lo); end
    endtask

    task automatic test_w8();
        int nb; bit seen;
        launch8(2'b00, 8'h80, 8'h80);
        wait_done8(nb, seen);
        checks++; if (!seen || hi8 !== 8'h40 || lo8 !== 8'h00) begin errors++; $display("FAIL w8_mult: got %h_%h want 40_00", hi8, lo8); end
        checks++; if (nb !== 10) begin errors++; $display("FAIL w8_latency: got %0d want 10", nb); end
        launch8(2'b10, 8'h81, 8'h03);
        wait_done8(nb, seen);
        checks++; if (!seen || lo8 !== 8'hD6 || hi8 !== 8'hFF) begin errors++; $display("FAIL w8_div: got q=%h r=%h want q=d6 r=ff", lo8, hi8); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_dbz();
        test_ignore_start();
        test_back_to_back();
        test_operand_change();
        test_midop_reset();
        test_w8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_muldiv_unit
`default_nettype wire
